// File: rtl/sram_like_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : sram_like_arbiter_if
//  Purpose  : Bundles the upstream (per-channel) and downstream SRAM-like
//             req/addr_ok/data_ok buses that surround the arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface sram_like_arbiter_if #(
    parameter int NCH = 2,
    parameter int AW  = 32,
    parameter int DW  = 32
);
    // Upstream side: one slot per master channel, flattened.
    logic [NCH-1:0]        s_req;
    logic [NCH-1:0]        s_wr;
    logic [2*NCH-1:0]      s_size;
    logic [NCH*AW-1:0]     s_addr;
    logic [NCH*DW/8-1:0]   s_wstrb;
    logic [NCH*DW-1:0]     s_wdata;
    logic [NCH-1:0]        s_addr_ok;
    logic [NCH-1:0]        s_data_ok;
    logic [DW-1:0]         s_rdata;

    // Downstream side: single request towards memory / AXI bridge.
    logic                  m_req;
    logic                  m_wr;
    logic [1:0]            m_size;
    logic [AW-1:0]         m_addr;
    logic [DW/8-1:0]       m_wstrb;
    logic [DW-1:0]         m_wdata;
    logic                  m_addr_ok;
    logic                  m_data_ok;
    logic [DW-1:0]         m_rdata;

    // Arbiter view.
    modport slave (
        input  s_req, s_wr, s_size, s_addr, s_wstrb, s_wdata,
        output s_addr_ok, s_data_ok, s_rdata,
        output m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata,
        input  m_addr_ok, m_data_ok, m_rdata
    );

    // Environment view: masters upstream plus memory downstream.
    modport master (
        output s_req, s_wr, s_size, s_addr, s_wstrb, s_wdata,
        input  s_addr_ok, s_data_ok, s_rdata,
        input  m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata,
        output m_addr_ok, m_data_ok, m_rdata
    );
endinterface
`default_nettype wire

// File: rtl/sram_like_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_like_arbiter
//  Purpose  : Arbitrates NCH SRAM-like masters onto one SRAM-like slave bus,
//             one transaction in flight, fixed-priority or round-robin.
//  Revision : 1.0  initial release
// ============================================================================
module sram_like_arbiter #(
    parameter int NCH     = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RR_MODE = 0
) (
    input  wire logic          clk,
    input  wire logic          rst,
    sram_like_arbiter_if.slave bus
);

    localparam int c_gw = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_gw-1:0] r_grant;
    logic [c_gw-1:0] w_winner;
    logic            w_any;
    logic [NCH-1:0]  w_addr_ok;
    logic [NCH-1:0]  w_data_ok;

    logic            r_wr;
    logic [1:0]      r_size;
    logic [AW-1:0]   r_addr;
    logic [DW/8-1:0] r_wstrb;
    logic [DW-1:0]   r_wdata;

    // Per-channel views of the flattened request fields.
    logic            w_ch_wr    [NCH];
    logic [1:0]      w_ch_size  [NCH];
    logic [AW-1:0]   w_ch_addr  [NCH];
    logic [DW/8-1:0] w_ch_wstrb [NCH];
    logic [DW-1:0]   w_ch_wdata [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign w_ch_wr[i]    = bus.s_wr[i];
        assign w_ch_size[i]  = bus.s_size[2*i +: 2];
        assign w_ch_addr[i]  = bus.s_addr[i*AW +: AW];
        assign w_ch_wstrb[i] = bus.s_wstrb[i*(DW/8) +: DW/8];
        assign w_ch_wdata[i] = bus.s_wdata[i*DW +: DW];
    end

    assign w_any = |bus.s_req;

    if (RR_MODE == 0) begin : g_fixed
        // Lowest-indexed requester wins.
        always_comb begin
            w_winner = '0;
            for (int i = NCH - 1; i >= 0; i--) begin
                if (bus.s_req[i]) w_winner = c_gw'(i);
            end
        end
    end else begin : g_rr
        logic [c_gw-1:0] r_rr_ptr;
        logic [c_gw-1:0] w_hi;
        logic [c_gw-1:0] w_lo;
        logic            w_hi_vld;

        // First requester at or after the pointer, else wrap to lowest index.
        always_comb begin
            w_hi     = '0;
            w_lo     = '0;
            w_hi_vld = 1'b0;
            for (int i = NCH - 1; i >= 0; i--) begin
                if (bus.s_req[i]) begin
                    w_lo = c_gw'(i);
                    if (c_gw'(i) >= r_rr_ptr) begin
                        w_hi     = c_gw'(i);
                        w_hi_vld = 1'b1;
                    end
                end
            end
            w_winner = w_hi_vld ? w_hi : w_lo;
        end

        // Pointer moves past the channel just served once its data returns.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_rr_ptr <= '0;
            end else if (r_state == c_st_wait && bus.m_data_ok) begin
                r_rr_ptr <= (r_grant == c_gw'(NCH - 1)) ? '0 : r_grant + 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and combinational one-hot handshakes for the granted channel.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_ok   = '0;
        w_data_ok   = '0;
        case (r_state)
            c_st_idle: begin
                if (w_any) w_state_nxt = c_st_req;
            end
            c_st_req: begin
                if (bus.m_addr_ok) begin
                    w_addr_ok[r_grant] = 1'b1;
                    w_state_nxt        = c_st_wait;
                end
            end
            c_st_wait: begin
                if (bus.m_data_ok) begin
                    w_data_ok[r_grant] = 1'b1;
                    w_state_nxt        = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Capture the winner and its request fields; they stay frozen until idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant <= '0;
            r_wr    <= 1'b0;
            r_size  <= '0;
            r_addr  <= '0;
            r_wstrb <= '0;
            r_wdata <= '0;
        end else if (r_state == c_st_idle && w_any) begin
            r_grant <= w_winner;
            r_wr    <= w_ch_wr[w_winner];
            r_size  <= w_ch_size[w_winner];
            r_addr  <= w_ch_addr[w_winner];
            r_wstrb <= w_ch_wstrb[w_winner];
            r_wdata <= w_ch_wdata[w_winner];
        end
    end

    assign bus.m_req     = (r_state == c_st_req);
    assign bus.m_wr      = r_wr;
    assign bus.m_size    = r_size;
    assign bus.m_addr    = r_addr;
    assign bus.m_wstrb   = r_wstrb;
    assign bus.m_wdata   = r_wdata;
    assign bus.s_addr_ok = w_addr_ok;
    assign bus.s_data_ok = w_data_ok;
    assign bus.s_rdata   = bus.m_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_like_arbiter
//  Purpose  : Self-checking bench: a 2-channel fixed-priority arbiter and a
//             4-channel round-robin arbiter against a transaction-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_like_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Index 0 drives the 2-channel fixed-priority DUT, index 1 the 4-channel RR DUT.
    logic [1:0][3:0]   req;
    logic [1:0][3:0]   wr;
    logic [1:0][7:0]   size;
    logic [1:0][127:0] addr;
    logic [1:0][15:0]  wstrb;
    logic [1:0][127:0] wdata;
    logic [1:0]        maok;
    logic [1:0]        mdok;
    logic [1:0][31:0]  mrdata;

    wire  [1:0][3:0]   s_aok;
    wire  [1:0][3:0]   s_dok;
    wire  [1:0][31:0]  s_rd;
    wire  [1:0]        o_req;
    wire  [1:0]        o_wr;
    wire  [1:0][1:0]   o_size;
    wire  [1:0][31:0]  o_addr;
    wire  [1:0][3:0]   o_wstrb;
    wire  [1:0][31:0]  o_wdata;

    sram_like_arbiter_if #(.NCH(2), .AW(AW), .DW(DW)) bus_a ();
    sram_like_arbiter_if #(.NCH(4), .AW(AW), .DW(DW)) bus_b ();

    assign bus_a.s_req     = req[0][1:0];
    assign bus_a.s_wr      = wr[0][1:0];
    assign bus_a.s_size    = size[0][3:0];
    assign bus_a.s_addr    = addr[0][63:0];
    assign bus_a.s_wstrb   = wstrb[0][7:0];
    assign bus_a.s_wdata   = wdata[0][63:0];
    assign bus_a.m_addr_ok = maok[0];
    assign bus_a.m_data_ok = mdok[0];
    assign bus_a.m_rdata   = mrdata[0];
    assign s_aok[0]        = {2'b00, bus_a.s_addr_ok};
    assign s_dok[0]        = {2'b00, bus_a.s_data_ok};
    assign s_rd[0]         = bus_a.s_rdata;
    assign o_req[0]        = bus_a.m_req;
    assign o_wr[0]         = bus_a.m_wr;
    assign o_size[0]       = bus_a.m_size;
    assign o_addr[0]       = bus_a.m_addr;
    assign o_wstrb[0]      = bus_a.m_wstrb;
    assign o_wdata[0]      = bus_a.m_wdata;

    assign bus_b.s_req     = req[1];
    assign bus_b.s_wr      = wr[1];
    assign bus_b.s_size    = size[1];
    assign bus_b.s_addr    = addr[1];
    assign bus_b.s_wstrb   = wstrb[1];
    assign bus_b.s_wdata   = wdata[1];
    assign bus_b.m_addr_ok = maok[1];
    assign bus_b.m_data_ok = mdok[1];
    assign bus_b.m_rdata   = mrdata[1];
    assign s_aok[1]        = bus_b.s_addr_ok;
    assign s_dok[1]        = bus_b.s_data_ok;
    assign s_rd[1]         = bus_b.s_rdata;
    assign o_req[1]        = bus_b.m_req;
    assign o_wr[1]         = bus_b.m_wr;
    assign o_size[1]       = bus_b.m_size;
    assign o_addr[1]       = bus_b.m_addr;
    assign o_wstrb[1]      = bus_b.m_wstrb;
    assign o_wdata[1]      = bus_b.m_wdata;

    sram_like_arbiter #(.NCH(2), .AW(AW), .DW(DW), .RR_MODE(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    sram_like_arbiter #(.NCH(4), .AW(AW), .DW(DW), .RR_MODE(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Reference model state.
    int nch [2];
    int rrm [2];
    int rr  [2];
    int n_chk;
    int n_fail;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Winner according to the arbitration rule of each DUT.
    function automatic int pick(input int d, input logic [3:0] p);
        int i;
        if (rrm[d] == 0) begin
            for (int k = 0; k < nch[d]; k++) if (p[k]) return k;
        end else begin
            for (int k = 0; k < nch[d]; k++) begin
                i = (rr[d] + k) % nch[d];
                if (p[i]) return i;
            end
        end
        return 0;
    endfunction

    function automatic logic [3:0] mask(input int d);
        return (nch[d] == 2) ? 4'b0011 : 4'b1111;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ch(input int d, input int c);
        wr[d][c]            = 1'($urandom);
        size[d][2*c +: 2]   = 2'($urandom_range(0, 2));
        addr[d][32*c +: 32] = $urandom;
        wstrb[d][4*c +: 4]  = 4'($urandom);
        wdata[d][32*c +: 32] = $urandom;
    endtask

    task automatic rand_fields(input int d);
        for (int c = 0; c < 4; c++) rand_ch(d, c);
    endtask

    // One transaction: idle cycle with pattern, d1 extra REQ cycles before
    // addr_ok, d2 extra WAIT cycles before data_ok (or reset when abort).
    task automatic do_txn(input int d, input logic [3:0] pat, input int d1,
                          input int d2, input logic [31:0] rd, input bit abort);
        int         g;
        logic [3:0] oh;
        logic       e_wr;
        logic [1:0] e_size;
        logic [31:0] e_addr;
        logic [3:0] e_wstrb;
        logic [31:0] e_wdata;

        req[d]  = pat;
        maok[d] = 1'b0;
        mdok[d] = 1'b0;
        #1;
        chk("idle_mreq", 64'(o_req[d]), 64'd0);
        chk("idle_aok",  64'(s_aok[d]), 64'd0);
        chk("idle_dok",  64'(s_dok[d]), 64'd0);
        g       = pick(d, pat);
        oh      = 4'(1 << g);
        e_wr    = wr[d][g];
        e_size  = size[d][2*g +: 2];
        e_addr  = addr[d][32*g +: 32];
        e_wstrb = wstrb[d][4*g +: 4];
        e_wdata = wdata[d][32*g +: 32];
        step();

        for (int i = 0; i <= d1; i++) begin
            if (i == d1) begin
                maok[d] = 1'b1;
            end else begin
                mdok[d] = 1'($urandom);
                req[d]  = 4'($urandom) & mask(d);
                for (int c = 0; c < nch[d]; c++) if (c != g) rand_ch(d, c);
            end
            #1;
            chk("req_mreq",  64'(o_req[d]),   64'd1);
            chk("req_wr",    64'(o_wr[d]),    64'(e_wr));
            chk("req_size",  64'(o_size[d]),  64'(e_size));
            chk("req_addr",  64'(o_addr[d]),  64'(e_addr));
            chk("req_wstrb", 64'(o_wstrb[d]), 64'(e_wstrb));
            chk("req_wdata", 64'(o_wdata[d]), 64'(e_wdata));
            chk("req_aok",   64'(s_aok[d]),   (i == d1) ? 64'(oh) : 64'd0);
            chk("req_dok",   64'(s_dok[d]),   64'd0);
            step();
            maok[d] = 1'b0;
            mdok[d] = 1'b0;
        end

        req[d] = 4'($urandom) & mask(d);
        for (int i = 0; i <= d2; i++) begin
            if (abort && i == d2) begin
                rst = 1'b1;
                step();
                rst     = 1'b0;
                mdok[d] = 1'b1;
                #1;
                chk("rst_mreq", 64'(o_req[d]), 64'd0);
                chk("rst_dok",  64'(s_dok[d]), 64'd0);
                chk("rst_aok",  64'(s_aok[d]), 64'd0);
                rr[0]   = 0;
                rr[1]   = 0;
                req[d]  = '0;
                mdok[d] = 1'b0;
                return;
            end
            if (i == d2) begin
                mdok[d]   = 1'b1;
                mrdata[d] = rd;
            end else begin
                mrdata[d] = $urandom;
            end
            #1;
            chk("wait_mreq", 64'(o_req[d]), 64'd0);
            chk("wait_aok",  64'(s_aok[d]), 64'd0);
            chk("wait_dok",  64'(s_dok[d]), (i == d2) ? 64'(oh) : 64'd0);
            if (i == d2) chk("wait_rdata", 64'(s_rd[d]), 64'(rd));
            step();
            mdok[d] = 1'b0;
        end
        if (rrm[d] != 0) rr[d] = (g + 1) % nch[d];
        req[d] = '0;
    endtask

    initial begin
        logic [3:0] pat;
        int         d;
        n_chk  = 0;
        n_fail = 0;
        nch[0] = 2; nch[1] = 4;
        rrm[0] = 0; rrm[1] = 1;
        rr[0]  = 0; rr[1]  = 0;
        rst    = 1'b1;
        req    = '0; wr = '0; size = '0; addr = '0; wstrb = '0; wdata = '0;
        maok   = '0; mdok = '0; mrdata = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_state_mreq",  64'(o_req[k]),  64'd0);
            chk("rst_state_aok",   64'(s_aok[k]),  64'd0);
            chk("rst_state_dok",   64'(s_dok[k]),  64'd0);
            chk("rst_state_addr",  64'(o_addr[k]), 64'd0);
            chk("rst_state_wdata", 64'(o_wdata[k]), 64'd0);
        end

        // Single read from channel 1.
        rand_fields(0);
        wr[0][1] = 1'b0;
        addr[0][63:32] = 32'hBFC0_0000;
        do_txn(0, 4'b0010, 1, 1, 32'h3C08_0001, 1'b0);

        // Byte write with delayed addr_ok.
        rand_fields(0);
        wr[0][0]        = 1'b1;
        size[0][1:0]    = 2'd0;
        addr[0][31:0]   = 32'h8000_0003;
        wstrb[0][3:0]   = 4'b1000;
        wdata[0][31:0]  = 32'hAB00_0000;
        do_txn(0, 4'b0001, 5, 0, $urandom, 1'b0);

        // Fixed priority: both channels requesting, channel 0 keeps winning.
        repeat (4) begin
            rand_fields(0);
            do_txn(0, 4'b0011, $urandom_range(0, 2), $urandom_range(0, 2), $urandom, 1'b0);
        end

        // Round robin: alternation, then pointer at 2 with requests on 1 and 3.
        repeat (4) begin
            rand_fields(1);
            do_txn(1, 4'b0011, $urandom_range(0, 2), $urandom_range(0, 2), $urandom, 1'b0);
        end
        repeat (2) begin
            rand_fields(1);
            do_txn(1, 4'b1010, 0, 0, $urandom, 1'b0);
        end

        // Reset while waiting for data, then normal service.
        rand_fields(0);
        do_txn(0, 4'b0010, 0, 2, $urandom, 1'b1);
        rand_fields(0);
        do_txn(0, 4'b0010, 0, 1, $urandom, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            d = int'($urandom_range(0, 1));
            do begin
                pat = 4'($urandom) & mask(d);
            end while (pat == 4'd0);
            rand_fields(d);
            do_txn(d, pat, $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                   ($urandom_range(0, 15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
